cla_pipe_addsub: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor for the CPU datapath. It supersedes the fixed 8-bit combinational CLA block. The operand width is split into BLK-bit lookahead slices, and one slice is resolved per pipeline stage, with the block carry registered between stages. A valid/ready handshake lets the execute stage issue one operation per cycle and stall on back-pressure. The block produces sum, carry-out, signed overflow and zero flags, plus a pass-through tag for the ALU/bypass logic.

---
 rtl/cla_pipe_addsub_if.sv | 29 ++
 rtl/cla_pipe_addsub.sv | 138 +++++++++++++
 tb/tb_cla_pipe_addsub.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cla_pipe_addsub_if.sv
// rtl/cla_pipe_addsub_if.sv - operation/result handshake bundle for the pipelined add/sub
interface cla_pipe_addsub_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;
    logic             in_sub;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_x, in_y, in_sub, in_tag, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag
    );

    modport slave (
        input  in_valid, in_x, in_y, in_sub, in_tag, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag
    );
endinterface

// File: rtl/cla_pipe_addsub.sv
// rtl/cla_pipe_addsub.sv - pipelined carry-lookahead adder/subtractor, one slice per stage
module cla_pipe_addsub #(
    parameter int WIDTH = 32,
    parameter int BLK   = 8,
    parameter int TAG_W = 5
) (
    input logic              clock,
    input logic              reset_n,
    cla_pipe_addsub_if.slave bus
);
    localparam int N = WIDTH / BLK;

    generate
        if (WIDTH % BLK != 0) begin : g_width_check
            $error("cla_pipe_addsub: WIDTH must be a multiple of BLK");
        end
    endgenerate

    // One BLK-bit lookahead slice: every carry is a flat sum of generate terms
    // gated by the propagate chain down to the slice carry-in. Returns {cout, sum}.
    function automatic logic [BLK:0] cla_slice(input logic [BLK-1:0] a,
                                               input logic [BLK-1:0] b,
                                               input logic           cin);
        logic [BLK-1:0] p;
        logic [BLK-1:0] g;
        logic [BLK:0]   c;
        logic           pp;
        p    = a | b;
        g    = a & b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < BLK; i++) begin
            pp     = 1'b1;
            c[i+1] = 1'b0;
            for (int j = i; j >= 0; j--) begin
                c[i+1] = c[i+1] | (pp & g[j]);
                pp     = pp & p[j];
            end
            c[i+1] = c[i+1] | (pp & cin);
        end
        return {c[BLK], a ^ b ^ c[BLK-1:0]};
    endfunction

    // Stage registers: x/y are the prepared operands, s the partial sum,
    // c the carry out of the slice this stage resolved.
    logic             stg_v   [N];
    logic [TAG_W-1:0] stg_tag [N];
    logic [WIDTH-1:0] stg_x   [N];
    logic [WIDTH-1:0] stg_y   [N];
    logic [WIDTH-1:0] stg_s   [N];
    logic             stg_c   [N];
    logic             ovf_q;
    logic             zero_q;

    // What each stage sees as its input this cycle.
    logic             src_v   [N];
    logic [TAG_W-1:0] src_tag [N];
    logic [WIDTH-1:0] src_x   [N];
    logic [WIDTH-1:0] src_y   [N];
    logic [WIDTH-1:0] src_s   [N];
    logic             src_c   [N];

    logic [BLK:0]     slice   [N];
    logic [WIDTH-1:0] nxt_s   [N];
    logic             nxt_c   [N];
    logic             nxt_ovf;
    logic             nxt_zero;
    logic             adv;

    // The whole pipe moves together; a stalled output freezes every stage.
    assign adv          = bus.out_ready | ~stg_v[N-1];
    assign bus.in_ready = adv;

    // Stage 0 takes the prepared operation; later stages take their predecessor.
    always_comb begin
        src_v[0]   = bus.in_valid;
        src_tag[0] = bus.in_tag;
        src_x[0]   = bus.in_x;
        src_y[0]   = bus.in_sub ? ~bus.in_y : bus.in_y;
        src_s[0]   = '0;
        src_c[0]   = bus.in_sub;
        for (int k = 1; k < N; k++) begin
            src_v[k]   = stg_v[k-1];
            src_tag[k] = stg_tag[k-1];
            src_x[k]   = stg_x[k-1];
            src_y[k]   = stg_y[k-1];
            src_s[k]   = stg_s[k-1];
            src_c[k]   = stg_c[k-1];
        end
    end

    // Resolve slice k in stage k and derive the final flags from the last stage.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            slice[k] = cla_slice(src_x[k][k*BLK +: BLK], src_y[k][k*BLK +: BLK], src_c[k]);
            nxt_s[k] = src_s[k];
            nxt_s[k][k*BLK +: BLK] = slice[k][BLK-1:0];
            nxt_c[k] = slice[k][BLK];
        end
        nxt_ovf  = (src_x[N-1][WIDTH-1] == src_y[N-1][WIDTH-1]) &
                   (nxt_s[N-1][WIDTH-1] != src_x[N-1][WIDTH-1]);
        nxt_zero = ~|nxt_s[N-1];
    end

    // Pipeline registers; reset empties the pipe and zeroes every payload.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N; k++) begin
                stg_v[k]   <= 1'b0;
                stg_tag[k] <= '0;
                stg_x[k]   <= '0;
                stg_y[k]   <= '0;
                stg_s[k]   <= '0;
                stg_c[k]   <= 1'b0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b1;
        end else if (adv) begin
            for (int k = 0; k < N; k++) begin
                stg_v[k]   <= src_v[k];
                stg_tag[k] <= src_tag[k];
                stg_x[k]   <= src_x[k];
                stg_y[k]   <= src_y[k];
                stg_s[k]   <= nxt_s[k];
                stg_c[k]   <= nxt_c[k];
            end
            ovf_q  <= nxt_ovf;
            zero_q <= nxt_zero;
        end
    end

    assign bus.out_valid = stg_v[N-1];
    assign bus.out_sum   = stg_s[N-1];
    assign bus.out_cout  = stg_c[N-1];
    assign bus.out_ovf   = ovf_q;
    assign bus.out_zero  = zero_q;
    assign bus.out_tag   = stg_tag[N-1];
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// tb/tb_cla_pipe_addsub.sv - bench for cla_pipe_addsub across four width/slice configurations
module tb_cla_pipe_addsub;
    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic [4:0]  tag;
    } res_t;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        sub;
        logic [4:0]  tag;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   errors  = 0;
    int   checks  = 0;

    logic        r_iv   [4];
    logic [63:0] r_x    [4];
    logic [63:0] r_y    [4];
    logic        r_sub  [4];
    logic [4:0]  r_itag [4];
    logic        r_or   [4];
    logic        r_ir   [4];
    logic        r_ov   [4];
    logic [63:0] r_sum  [4];
    logic        r_cout [4];
    logic        r_ovf  [4];
    logic        r_zero [4];
    logic [4:0]  r_otag [4];

    int cfg_w [4] = '{32, 16, 8, 64};

    always #5 clock = ~clock;

    for (genvar g = 0; g < 4; g++) begin : g_cfg
        localparam int W = (g == 0) ? 32 : (g == 1) ? 16 : (g == 2) ? 8 : 64;
        localparam int B = (g == 0) ? 8 : (g == 1) ? 4 : (g == 2) ? 8 : 16;
        cla_pipe_addsub_if #(.WIDTH(W), .TAG_W(5)) bus ();
        cla_pipe_addsub #(.WIDTH(W), .BLK(B), .TAG_W(5)) dut (
            .clock   (clock),
            .reset_n (reset_n),
            .bus     (bus)
        );
        assign bus.in_valid  = r_iv[g];
        assign bus.in_x      = r_x[g][W-1:0];
        assign bus.in_y      = r_y[g][W-1:0];
        assign bus.in_sub    = r_sub[g];
        assign bus.in_tag    = r_itag[g];
        assign bus.out_ready = r_or[g];
        assign r_ir[g]   = bus.in_ready;
        assign r_ov[g]   = bus.out_valid;
        assign r_sum[g]  = 64'(bus.out_sum);
        assign r_cout[g] = bus.out_cout;
        assign r_ovf[g]  = bus.out_ovf;
        assign r_zero[g] = bus.out_zero;
        assign r_otag[g] = bus.out_tag;
    end

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mask_of(input int w);
        return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    endfunction

    // Reference: plain unsigned and signed arithmetic on the true operand values.
    function automatic res_t ref_op(input int w, input logic [63:0] x, input logic [63:0] y,
                                    input logic sub, input logic [4:0] tag);
        res_t               r;
        logic [63:0]        mask;
        logic [65:0]        ux;
        logic [65:0]        uy;
        logic signed [65:0] sx;
        logic signed [65:0] sy;
        logic signed [65:0] sr;
        logic signed [65:0] maxs;
        logic signed [65:0] mins;
        mask = mask_of(w);
        ux   = {2'b00, x};
        uy   = {2'b00, y};
        sx   = x[w-1] ? $signed({2'b11, x | ~mask}) : $signed({2'b00, x});
        sy   = y[w-1] ? $signed({2'b11, y | ~mask}) : $signed({2'b00, y});
        if (sub) begin
            sr     = sx - sy;
            r.cout = (ux >= uy);
            r.sum  = (x - y) & mask;
        end else begin
            sr     = sx + sy;
            r.cout = ((ux + uy) > {2'b00, mask});
            r.sum  = (x + y) & mask;
        end
        maxs  = $signed({2'b00, mask >> 1});
        mins  = -maxs - 66'sd1;
        r.ovf  = (sr > maxs) || (sr < mins);
        r.zero = (r.sum == 64'd0);
        r.tag  = tag;
        return r;
    endfunction

    function automatic logic [63:0] pick(input int w);
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0:       v = 64'd0;
            1:       v = {64{1'b1}};
            2:       v = 64'd1 << (w - 1);
            3:       v = (64'd1 << (w - 1)) - 64'd1;
            4:       v = 64'd1;
            default: v = {$urandom, $urandom};
        endcase
        return v & mask_of(w);
    endfunction

    task automatic run_vec(input vec_t v, input string name);
        int lat;
        @(negedge clock);
        r_iv[0] = 1'b1; r_x[0] = 64'(v.x); r_y[0] = 64'(v.y);
        r_sub[0] = v.sub; r_itag[0] = v.tag; r_or[0] = 1'b1;
        @(negedge clock);
        r_iv[0] = 1'b0;
        lat = 1;
        while (!r_ov[0] && lat < 12) begin
            @(negedge clock);
            lat++;
        end
        check({name, " latency"}, 72'(lat), 72'd4);
        check({name, " sum"},  72'(r_sum[0]),  72'(v.sum));
        check({name, " cout"}, 72'(r_cout[0]), 72'(v.cout));
        check({name, " ovf"},  72'(r_ovf[0]),  72'(v.ovf));
        check({name, " zero"}, 72'(r_zero[0]), 72'(v.zero));
        check({name, " tag"},  72'(r_otag[0]), 72'(v.tag));
    endtask

    task automatic run_rand(input int g);
        res_t q[$];
        res_t e;
        int   w;
        int   acc;
        int   cyc;
        w   = cfg_w[g];
        acc = 0;
        for (cyc = 0; cyc < 20000 && (acc < 1000 || q.size() > 0); cyc++) begin
            @(negedge clock);
            r_or[g] = ($urandom_range(0, 3) != 0);
            if (acc < 1000) begin
                r_iv[g]   = ($urandom_range(0, 3) != 0);
                r_x[g]    = pick(w);
                r_y[g]    = pick(w);
                r_sub[g]  = $urandom_range(0, 1) == 1;
                r_itag[g] = 5'($urandom);
            end else begin
                r_iv[g] = 1'b0;
            end
            #1;
            if (r_iv[g] && r_ir[g]) begin
                q.push_back(ref_op(w, r_x[g], r_y[g], r_sub[g], r_itag[g]));
                acc++;
            end
            if (r_ov[g] && r_or[g]) begin
                if (q.size() == 0) begin
                    check($sformatf("rand w%0d spurious result", w), 72'(1), 72'(0));
                end else begin
                    e = q.pop_front();
                    check($sformatf("rand w%0d result", w),
                          {r_sum[g], r_cout[g], r_ovf[g], r_zero[g], r_otag[g]}, e);
                end
            end
        end
        check($sformatf("rand w%0d completion", w), 72'(acc + q.size()), 72'(1000));
        r_iv[g] = 1'b0;
        r_or[g] = 1'b1;
    endtask

    vec_t        vtab [8];
    logic [31:0] bx [7];
    logic [31:0] by [7];
    res_t        be;
    int          nxt;
    int          got;
    int          stall;
    int          seen;
    int          extra;

    initial begin
        for (int g = 0; g < 4; g++) begin
            r_iv[g] = 1'b0; r_x[g] = '0; r_y[g] = '0; r_sub[g] = 1'b0;
            r_itag[g] = '0; r_or[g] = 1'b0;
        end
        vtab[0] = '{32'h000000FF, 32'h00000001, 1'b0, 5'd3,  32'h00000100, 1'b0, 1'b0, 1'b0};
        vtab[1] = '{32'h00000005, 32'h00000007, 1'b1, 5'd4,  32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vtab[2] = '{32'h00000007, 32'h00000005, 1'b1, 5'd5,  32'h00000002, 1'b1, 1'b0, 1'b0};
        vtab[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 5'd6,  32'h80000000, 1'b0, 1'b1, 1'b0};
        vtab[4] = '{32'h80000000, 32'h00000001, 1'b1, 5'd7,  32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vtab[5] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 5'd8,  32'h00000000, 1'b1, 1'b0, 1'b1};
        vtab[6] = '{32'h00000005, 32'h00000005, 1'b1, 5'd9,  32'h00000000, 1'b1, 1'b0, 1'b1};
        vtab[7] = '{32'h80000000, 32'h80000000, 1'b0, 5'd31, 32'h00000000, 1'b1, 1'b1, 1'b1};

        // Reset state, with out_ready low to show in_ready does not wait on it.
        #22;
        check("reset out_valid", 72'(r_ov[0]),   72'd0);
        check("reset in_ready",  72'(r_ir[0]),   72'd1);
        check("reset out_sum",   72'(r_sum[0]),  72'd0);
        check("reset out_cout",  72'(r_cout[0]), 72'd0);
        check("reset out_ovf",   72'(r_ovf[0]),  72'd0);
        check("reset out_zero",  72'(r_zero[0]), 72'd1);
        check("reset out_tag",   72'(r_otag[0]), 72'd0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vtab[i], $sformatf("vec%0d", i));

        // Back-pressure: tags 1..6 back to back, output stalled 3 cycles once tag 1 arrives.
        for (int t = 1; t <= 6; t++) begin
            bx[t] = $urandom;
            by[t] = $urandom;
        end
        bx[0] = '0; by[0] = '0;
        nxt = 1; got = 1; stall = 0; seen = 0;
        for (int c = 0; c < 40 && got <= 6; c++) begin
            @(negedge clock);
            if (seen == 0 && r_ov[0]) begin
                seen  = 1;
                stall = 3;
            end
            r_or[0] = (stall == 0);
            r_iv[0] = (nxt <= 6);
            if (nxt <= 6) begin
                r_x[0] = 64'(bx[nxt]); r_y[0] = 64'(by[nxt]);
                r_sub[0] = 1'b0; r_itag[0] = 5'(nxt);
            end
            #1;
            if (stall > 0) begin
                be = ref_op(32, 64'(bx[1]), 64'(by[1]), 1'b0, 5'd1);
                check("stall in_ready",  72'(r_ir[0]),   72'd0);
                check("stall out_valid", 72'(r_ov[0]),   72'd1);
                check("stall out_sum",   72'(r_sum[0]),  72'(be.sum));
                check("stall out_tag",   72'(r_otag[0]), 72'd1);
                stall--;
            end
            if (r_iv[0] && r_ir[0]) nxt++;
            if (r_ov[0] && r_or[0]) begin
                be = ref_op(32, 64'(bx[got]), 64'(by[got]), 1'b0, 5'(got));
                check($sformatf("bp result %0d", got),
                      {r_sum[0], r_cout[0], r_ovf[0], r_zero[0], r_otag[0]}, be);
                got++;
            end
        end
        r_iv[0] = 1'b0;
        check("bp all emitted", 72'(got), 72'd7);
        extra = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (r_ov[0]) extra++;
        end
        check("bp no duplicates", 72'(extra), 72'd0);

        // Reset mid-flight: three ops held in the pipe behind a stalled output.
        r_or[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            r_iv[0] = 1'b1; r_x[0] = 64'(i + 10); r_y[0] = 64'd1;
            r_sub[0] = 1'b0; r_itag[0] = 5'(i + 20);
        end
        @(negedge clock);
        r_iv[0] = 1'b0;
        for (int c = 0; c < 8 && !r_ov[0]; c++) @(negedge clock);
        check("mid out_valid before reset", 72'(r_ov[0]), 72'd1);
        #1 reset_n = 1'b0;
        #1;
        check("mid reset out_valid", 72'(r_ov[0]),   72'd0);
        check("mid reset in_ready",  72'(r_ir[0]),   72'd1);
        check("mid reset out_sum",   72'(r_sum[0]),  72'd0);
        check("mid reset out_zero",  72'(r_zero[0]), 72'd1);
        check("mid reset out_tag",   72'(r_otag[0]), 72'd0);
        #1 reset_n = 1'b1;
        r_or[0] = 1'b1;
        extra = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (r_ov[0]) extra++;
        end
        check("mid reset discarded", 72'(extra), 72'd0);
        run_vec(vtab[0], "post reset");

        for (int g = 0; g < 4; g++) run_rand(g);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
